// File: rtl/commit_unit_pkg.sv
// commit_unit_pkg: shared types for the in-order retirement stage.
//   commit_state_t : retirement FSM states
//   rob_entry_t    : view of the ROB head entry seen by the commit stage
//   rob_commit_t   : registered regfile write / RAT release bundle
package commit_unit_pkg;

  localparam int unsigned Xlen      = 32;
  localparam int unsigned RegAddrW  = 5;
  localparam int unsigned RobIdxW   = 5;
  localparam int unsigned FlushCntW = 4;

  typedef enum logic [0:0] {
    StRun,
    StFlush
  } commit_state_t;

  typedef struct packed {
    logic                valid;
    logic                done;
    logic [RegAddrW-1:0] rd_addr;
    logic [Xlen-1:0]     rd_data;
    logic [RobIdxW-1:0]  rob_idx;
    logic                is_br;
    logic                mispred;
    logic [Xlen-1:0]     br_target;
  } rob_entry_t;

  typedef struct packed {
    logic                rf_we;
    logic [RegAddrW-1:0] rd_addr;
    logic [Xlen-1:0]     rd_data;
    logic [RobIdxW-1:0]  rob_idx;
  } rob_commit_t;

  // x0 is hardwired to zero, so retiring into it never writes the regfile.
  function automatic logic writes_rd(logic [RegAddrW-1:0] rd);
    return rd != '0;
  endfunction

endpackage

// File: rtl/commit_unit_if.sv
// commit_unit_if: ROB head view plus commit-stage outputs.
//   master : ROB/environment side, drives the head_* fields and rob_empty_i
//   slave  : commit unit, drives dequeue, regfile write, flush, redirect, instret
interface commit_unit_if
  import commit_unit_pkg::*;
#(
  parameter int unsigned ROB_IDX_W = RobIdxW
);
  logic                 rob_empty_i;
  logic                 head_valid_i;
  logic                 head_done_i;
  logic [RegAddrW-1:0]  head_rd_addr_i;
  logic [Xlen-1:0]      head_rd_data_i;
  logic [ROB_IDX_W-1:0] head_rob_idx_i;
  logic                 head_is_br_i;
  logic                 head_mispred_i;
  logic [Xlen-1:0]      head_br_target_i;

  logic                 dequeue_o;
  logic                 rf_we_o;
  logic [RegAddrW-1:0]  rf_rd_addr_o;
  logic [Xlen-1:0]      rf_rd_data_o;
  logic [ROB_IDX_W-1:0] rf_rob_idx_o;
  logic                 flush_o;
  logic                 redirect_valid_o;
  logic [Xlen-1:0]      redirect_pc_o;
  logic [63:0]          retired_count_o;

  modport master (
    output rob_empty_i, head_valid_i, head_done_i, head_rd_addr_i, head_rd_data_i,
           head_rob_idx_i, head_is_br_i, head_mispred_i, head_br_target_i,
    input  dequeue_o, rf_we_o, rf_rd_addr_o, rf_rd_data_o, rf_rob_idx_o, flush_o,
           redirect_valid_o, redirect_pc_o, retired_count_o
  );

  modport slave (
    input  rob_empty_i, head_valid_i, head_done_i, head_rd_addr_i, head_rd_data_i,
           head_rob_idx_i, head_is_br_i, head_mispred_i, head_br_target_i,
    output dequeue_o, rf_we_o, rf_rd_addr_o, rf_rd_data_o, rf_rob_idx_o, flush_o,
           redirect_valid_o, redirect_pc_o, retired_count_o
  );

endinterface

// File: rtl/commit_unit.sv
// commit_unit: in-order retirement stage behind the reorder buffer.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : commit_unit_if.slave
//     in  : rob_empty_i, head_* (ROB head entry fields)
//     out : dequeue_o (combinational ROB pop), rf_* (registered regfile write and
//           RAT release tag), flush_o / redirect_* (mispredict recovery),
//           retired_count_o (instret)
// A done head retires each cycle in StRun. A mispredicted branch retires normally,
// then the unit holds flush_o for FLUSH_CYCLES cycles with dequeue blocked, and
// pulses redirect_valid_o once with the corrected PC.
module commit_unit
  import commit_unit_pkg::*;
#(
  parameter int unsigned ROB_IDX_W    = 5,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input logic           clk,
  input logic           rst,
  commit_unit_if.slave  bus
);

  if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 15) begin : g_bad_flush_cycles
    $error("FLUSH_CYCLES must be in 1..15");
  end
  if (ROB_IDX_W != RobIdxW) begin : g_bad_rob_idx_w
    $error("ROB_IDX_W must match commit_unit_pkg::RobIdxW");
  end

  localparam logic [FlushCntW-1:0] FlushLoad = FlushCntW'(FLUSH_CYCLES - 1);

  commit_state_t        state_q;
  logic [FlushCntW-1:0] flush_cnt_q;
  rob_commit_t          commit_q;
  logic                 flush_q;
  logic                 redirect_valid_q;
  logic [Xlen-1:0]      redirect_pc_q;
  logic [63:0]          retired_q;

  rob_entry_t head;
  logic       commit;
  logic       mispredict;

  always_comb begin
    head.valid     = bus.head_valid_i;
    head.done      = bus.head_done_i;
    head.rd_addr   = bus.head_rd_addr_i;
    head.rd_data   = bus.head_rd_data_i;
    head.rob_idx   = bus.head_rob_idx_i;
    head.is_br     = bus.head_is_br_i;
    head.mispred   = bus.head_mispred_i;
    head.br_target = bus.head_br_target_i;

    // Head fields are ignored while flushing: the ROB is being squashed.
    commit     = (state_q == StRun) && head.valid && head.done && !bus.rob_empty_i;
    mispredict = commit && head.is_br && head.mispred;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= StRun;
      flush_cnt_q      <= '0;
      commit_q         <= '0;
      flush_q          <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      retired_q        <= '0;
    end else begin
      commit_q.rf_we   <= commit && writes_rd(head.rd_addr);
      redirect_valid_q <= 1'b0;

      if (commit) begin
        commit_q.rd_addr <= head.rd_addr;
        commit_q.rd_data <= head.rd_data;
        commit_q.rob_idx <= head.rob_idx;
        retired_q        <= retired_q + 64'd1;
      end

      unique case (state_q)
        StRun: begin
          if (mispredict) begin
            state_q          <= StFlush;
            flush_cnt_q      <= FlushLoad;
            flush_q          <= 1'b1;
            redirect_valid_q <= 1'b1;
            redirect_pc_q    <= head.br_target;
          end
        end
        StFlush: begin
          if (flush_cnt_q == '0) begin
            state_q <= StRun;
            flush_q <= 1'b0;
          end else begin
            flush_cnt_q <= flush_cnt_q - 1'b1;
          end
        end
        default: begin
          state_q <= StRun;
          flush_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.dequeue_o        = commit;
  assign bus.rf_we_o          = commit_q.rf_we;
  assign bus.rf_rd_addr_o     = commit_q.rd_addr;
  assign bus.rf_rd_data_o     = commit_q.rd_data;
  assign bus.rf_rob_idx_o     = commit_q.rob_idx;
  assign bus.flush_o          = flush_q;
  assign bus.redirect_valid_o = redirect_valid_q;
  assign bus.redirect_pc_o    = redirect_pc_q;
  assign bus.retired_count_o  = retired_q;

endmodule

// File: tb/tb_commit_unit.sv
// Scoreboard bench for commit_unit: the stimulus pushes the hand-computed result of
// each retirement it expects; a monitor pops an entry whenever dequeue_o is seen and
// checks the registered outputs one edge later.
module tb_commit_unit;
  import commit_unit_pkg::*;

  typedef struct {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] data;
    logic [4:0]  idx;
    logic        redir;
    logic [31:0] pc;
    logic [63:0] count;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  commit_unit_if #(.ROB_IDX_W(5)) bus ();

  commit_unit #(.ROB_IDX_W(5), .FLUSH_CYCLES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic drive(input logic empty, input logic valid, input logic done,
                       input logic [4:0] rd, input logic [31:0] data, input logic [4:0] idx,
                       input logic is_br, input logic mispred, input logic [31:0] target);
    bus.rob_empty_i      = empty;
    bus.head_valid_i     = valid;
    bus.head_done_i      = done;
    bus.head_rd_addr_i   = rd;
    bus.head_rd_data_i   = data;
    bus.head_rob_idx_i   = idx;
    bus.head_is_br_i     = is_br;
    bus.head_mispred_i   = mispred;
    bus.head_br_target_i = target;
  endtask

  task automatic idle();
    drive(1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic expect_retire(input logic we, input logic [4:0] rd, input logic [31:0] data,
                               input logic [4:0] idx, input logic redir, input logic [31:0] pc,
                               input logic [63:0] count);
    exp_t e;
    e.we = we; e.rd = rd; e.data = data; e.idx = idx;
    e.redir = redir; e.pc = pc; e.count = count;
    sb_q.push_back(e);
  endtask

  // Inputs change at posedge+2; registered outputs are checked at posedge+1.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Monitor: dequeue_o sampled on the falling edge, results checked after the next rise.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && bus.dequeue_o) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_dequeue", 64'(bus.dequeue_o), 64'd0);
        end else begin
          e = sb_q.pop_front();
          @(posedge clk);
          #1;
          chk("rf_we", 64'(bus.rf_we_o), 64'(e.we));
          chk("rf_rd_addr", 64'(bus.rf_rd_addr_o), 64'(e.rd));
          chk("rf_rd_data", 64'(bus.rf_rd_data_o), 64'(e.data));
          chk("rf_rob_idx", 64'(bus.rf_rob_idx_o), 64'(e.idx));
          chk("redirect_valid", 64'(bus.redirect_valid_o), 64'(e.redir));
          chk("redirect_pc", 64'(bus.redirect_pc_o), 64'(e.pc));
          chk("retired_count", bus.retired_count_o, e.count);
        end
      end
    end
  end

  initial begin
    idle();
    repeat (2) @(posedge clk);
    #2;
    chk("reset_dequeue", 64'(bus.dequeue_o), 64'd0);
    chk("reset_rf_we", 64'(bus.rf_we_o), 64'd0);
    chk("reset_flush", 64'(bus.flush_o), 64'd0);
    chk("reset_redirect", 64'(bus.redirect_valid_o), 64'd0);
    chk("reset_count", bus.retired_count_o, 64'd0);
    rst = 1'b0;
    step();

    // Simple retire.
    drive(1'b0, 1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 5'd3, 1'b0, 1'b0, 32'h0);
    expect_retire(1'b1, 5'd5, 32'hDEADBEEF, 5'd3, 1'b0, 32'h0, 64'd1);
    step();
    idle();
    step();
    chk("rf_we_single_pulse", 64'(bus.rf_we_o), 64'd0);

    // Head valid but not done: stall, then retire into x0.
    drive(1'b0, 1'b1, 1'b0, 5'd7, 32'h0BADF00D, 5'd4, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      #1 chk("stall_dequeue", 64'(bus.dequeue_o), 64'd0);
      step();
    end
    drive(1'b0, 1'b1, 1'b1, 5'd0, 32'h12345678, 5'd4, 1'b0, 1'b0, 32'h0);
    expect_retire(1'b0, 5'd0, 32'h12345678, 5'd4, 1'b0, 32'h0, 64'd2);
    step();

    // Three back-to-back retirements.
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 1'b1, 5'(10 + i), 32'h11111111 * (i + 1), 5'(5 + i), 1'b0, 1'b0, 32'h0);
      expect_retire(1'b1, 5'(10 + i), 32'h11111111 * (i + 1), 5'(5 + i), 1'b0, 32'h0,
                    64'(3 + i));
      step();
    end
    idle();
    step();

    // Mispredicted branch with link write; a done head waits out the flush.
    drive(1'b0, 1'b1, 1'b1, 5'd1, 32'h00001004, 5'd8, 1'b1, 1'b1, 32'h60000040);
    expect_retire(1'b1, 5'd1, 32'h00001004, 5'd8, 1'b1, 32'h60000040, 64'd6);
    step();
    drive(1'b0, 1'b1, 1'b1, 5'd9, 32'h00000BAD, 5'd9, 1'b0, 1'b0, 32'h0);
    chk("flush_cycle1", 64'(bus.flush_o), 64'd1);
    #1 chk("flush1_dequeue", 64'(bus.dequeue_o), 64'd0);
    step();
    chk("flush_cycle2", 64'(bus.flush_o), 64'd1);
    chk("redirect_one_cycle", 64'(bus.redirect_valid_o), 64'd0);
    chk("flush2_rf_we", 64'(bus.rf_we_o), 64'd0);
    #1 chk("flush2_dequeue", 64'(bus.dequeue_o), 64'd0);
    step();
    expect_retire(1'b1, 5'd9, 32'h00000BAD, 5'd9, 1'b0, 32'h60000040, 64'd7);
    chk("flush_dropped", 64'(bus.flush_o), 64'd0);
    chk("redirect_pc_held", 64'(bus.redirect_pc_o), 64'h60000040);
    step();

    // Correctly predicted branch: ordinary retire, no flush.
    drive(1'b0, 1'b1, 1'b1, 5'd2, 32'h00000044, 5'd10, 1'b1, 1'b0, 32'h70000000);
    expect_retire(1'b1, 5'd2, 32'h00000044, 5'd10, 1'b0, 32'h60000040, 64'd8);
    step();
    idle();
    chk("good_br_no_flush", 64'(bus.flush_o), 64'd0);
    step();

    // Empty ROB overrides a valid, done head.
    drive(1'b1, 1'b1, 1'b1, 5'd3, 32'hCAFEF00D, 5'd11, 1'b0, 1'b0, 32'h0);
    #1 chk("empty_dequeue", 64'(bus.dequeue_o), 64'd0);
    step();
    chk("empty_rf_we", 64'(bus.rf_we_o), 64'd0);
    chk("empty_count", bus.retired_count_o, 64'd8);

    // Asynchronous reset in the middle of a flush.
    drive(1'b0, 1'b1, 1'b1, 5'd0, 32'h0, 5'd11, 1'b1, 1'b1, 32'h80000000);
    expect_retire(1'b0, 5'd0, 32'h0, 5'd11, 1'b1, 32'h80000000, 64'd9);
    step();
    idle();
    chk("pre_reset_flush", 64'(bus.flush_o), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_flush", 64'(bus.flush_o), 64'd0);
    chk("async_rst_redirect_pc", 64'(bus.redirect_pc_o), 64'd0);
    chk("async_rst_count", bus.retired_count_o, 64'd0);
    step();
    rst = 1'b0;
    drive(1'b0, 1'b1, 1'b1, 5'd6, 32'h00000077, 5'd12, 1'b0, 1'b0, 32'h0);
    expect_retire(1'b1, 5'd6, 32'h00000077, 5'd12, 1'b0, 32'h0, 64'd1);
    #1 chk("post_reset_run_dequeue", 64'(bus.dequeue_o), 64'd1);
    step();
    idle();
    repeat (3) step();

    chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
